// File: rtl/add_seq16_pkg.sv
// Shared constants for the nibble-serial add/subtract sequencer.
package add_seq16_pkg;

  localparam int NIBBLE = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/add_seq16_sum4.sv
// 4-bit carry-lookahead adder; also exposes the carry into the MSB for overflow detection.
module add_seq16_sum4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_msb_o,
  output logic       c_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o     = p ^ c[3:0];
  assign c_msb_o = c[3];
  assign c_o     = c[4];

endmodule

// File: rtl/add_seq16.sv
// Low-area add/subtract unit: one 4-bit adder reused per clock, LSB nibble first,
// with valid/ready handshakes on both sides.
module add_seq16
  import add_seq16_pkg::*;
#(
  parameter int N_NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        op_sub,
  input  logic [NIBBLE*N_NIBBLES-1:0] a,
  input  logic [NIBBLE*N_NIBBLES-1:0] b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE*N_NIBBLES-1:0] result,
  output logic                        cout,
  output logic                        ovf,
  output logic                        zero
);

  localparam int W     = NIBBLE * N_NIBBLES;
  localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBBLES - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [NIBBLE-1:0] nib_s;
  logic              nib_c_msb;
  logic              nib_c;

  add_seq16_sum4 u_sum4 (
    .a_i     (a_q[idx_q*NIBBLE +: NIBBLE]),
    .b_i     (b_q[idx_q*NIBBLE +: NIBBLE]),
    .c_i     (carry_q),
    .s_o     (nib_s),
    .c_msb_o (nib_c_msb),
    .c_o     (nib_c)
  );

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[idx_q*NIBBLE +: NIBBLE] = nib_s;
        carry_d = nib_c;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = nib_c;
          ovf_d   = nib_c_msb ^ nib_c;
          zero_d  = (result_d == '0);
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers are reset too, so an aborted operation never leaves a partial result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_add_seq16.sv
// Scoreboard bench for add_seq16: expected results are queued at accept and compared at output.
module tb_add_seq16;

  typedef struct packed {
    logic [15:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;

  int n_cmp;
  int n_mis;
  exp_t exp_q[$];

  add_seq16 #(.N_NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic, overflow from the operand/result sign rule.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic msub);
    exp_t e;
    logic [16:0] full;
    if (msub) full = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
    else      full = {1'b0, ma} + {1'b0, mb};
    e.result = full[15:0];
    e.cout   = full[16];
    if (msub) e.ovf = (ma[15] != mb[15]) && (full[15] != ma[15]);
    else      e.ovf = (ma[15] == mb[15]) && (full[15] != ma[15]);
    e.zero   = (full[15:0] == 16'h0000);
    return e;
  endfunction

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tsub,
                       input int stall);
    exp_t e;
    int lat;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb; op_sub = tsub; in_valid = 1'b1;
    exp_q.push_back(model(ta, tb, tsub));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op_sub = 1'($urandom);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'd4);
    e = exp_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_result", 32'(result), 32'(e.result));
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("out_valid", 32'(out_valid), 32'd1);
    check("result", 32'(result), 32'(e.result));
    check("cout", 32'(cout), 32'(e.cout));
    check("ovf", 32'(ovf), 32'(e.ovf));
    check("zero", 32'(zero), 32'(e.zero));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd1);
    check("retain_result", 32'(result), 32'(e.result));
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    #25;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(16'h1234, 16'h0FED, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'h8000, 16'h0001, 1'b1, 0);
    do_op(16'h4321, 16'h1111, 1'b0, 5);
    do_op(16'h0003, 16'h0005, 1'b1, 0);

    // Abort mid-run: reset asserted while the third nibble is being processed.
    @(negedge clk);
    a = 16'h5555; b = 16'h1111; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #5 rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'hA5A5, 16'h5A5B, 1'b0, 1);

    for (int n = 0; n < 200; n++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
